// File: rtl/apb_tone_seq.sv
// apb_tone_seq: APB-programmed note FIFO sequencer driving a square-wave buzzer
// Ports:
//   i_pclk, i_preset          clock and synchronous active-high reset
//   i_psel, i_penable,        APB slave request; i_paddr[3:2] selects
//   i_pwrite, i_paddr,          CTRL (0x0), NOTE (0x4), STATUS (0x8), 0xC reserved
//   i_pwdata
//   o_prdata, o_pready        combinational read data, zero-wait-state ready
//   o_buzzer_tone             registered square-wave tone
//   o_irq                     level interrupt, IRQ_EN & PEND
module apb_tone_seq #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_pclk,
    input  logic        i_preset,
    input  logic [3:0]  i_paddr,
    input  logic [31:0] i_pwdata,
    input  logic        i_pwrite,
    input  logic        i_penable,
    input  logic        i_psel,
    output logic [31:0] o_prdata,
    output logic        o_pready,
    output logic        o_buzzer_tone,
    output logic        o_irq
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int TPM = TICK_HZ / 1000;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TPM + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    state_t        r_state, w_state_n;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          r_en, r_irq_en, r_pend, r_ovf, r_buzz;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_tk;
    logic [15:0]   r_half, r_tone, r_dur;
    logic          w_wr, w_wr_ctrl, w_wr_note, w_wr_stat, w_clr, w_en_n, w_stop;
    logic          w_empty, w_full, w_push, w_pop, w_drop;
    logic          w_tick, w_ms, w_done, w_avail, w_set_pend, w_toggle;
    logic [31:0]   w_head;
    logic [7:0]    w_cnt8;
    logic          w_unused;

    assign o_pready  = i_psel & i_penable;
    assign w_wr      = o_pready & i_pwrite;
    assign w_wr_ctrl = w_wr & (i_paddr[3:2] == 2'd0);
    assign w_wr_note = w_wr & (i_paddr[3:2] == 2'd1);
    assign w_wr_stat = w_wr & (i_paddr[3:2] == 2'd2);
    assign w_unused  = ^i_paddr[1:0];

    // A CTRL write that clears EN or pulses CLR stops playback at the same edge
    assign w_clr   = w_wr_ctrl & i_pwdata[1];
    assign w_en_n  = w_wr_ctrl ? i_pwdata[0] : r_en;
    assign w_stop  = w_clr | !w_en_n;

    assign w_empty = r_cnt == '0;
    assign w_full  = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_pop   = (r_state == S_LOAD) & !w_clr;
    // A slot freed by a same-cycle pop lets a push into a full FIFO through
    assign w_push  = w_wr_note & (!w_full | w_pop);
    assign w_drop  = w_wr_note & w_full & !w_pop;
    assign w_head  = r_mem[r_rp];
    assign w_avail = r_en & !w_empty;

    // Prescaler only runs in PLAY, so PLAY length is exactly DUR ms strobes
    assign w_tick   = (r_state == S_PLAY) & (r_pre == PW'(DIV - 1));
    assign w_ms     = w_tick & (r_tk == TW'(TPM - 1));
    assign w_done   = w_ms & (r_dur == 16'd1);
    assign w_toggle = w_tick & (r_half != 16'd0) & (r_tone == r_half - 16'd1);

    assign o_buzzer_tone = r_buzz;
    assign o_irq         = r_irq_en & r_pend;
    assign w_cnt8        = 8'(r_cnt);
    assign o_prdata = !(i_psel & !i_pwrite) ? 32'd0 :
                      (i_paddr[3:2] == 2'd0) ? {29'd0, r_irq_en, 1'b0, r_en} :
                      (i_paddr[3:2] == 2'd2) ? {16'd0, w_cnt8, 3'd0, r_ovf, r_pend, w_empty, w_full, r_state != S_IDLE} :
                      32'd0;

    always_comb begin
        w_state_n  = r_state;
        w_set_pend = 1'b0;
        case (r_state)
            S_IDLE:  w_state_n = w_avail ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_n = S_PLAY;
            S_PLAY:  if (w_done) begin
                w_state_n  = w_avail ? S_LOAD : S_IDLE;
                w_set_pend = !w_avail;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_stop) begin
            w_state_n  = S_IDLE;
            w_set_pend = 1'b0;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (w_push) r_mem[r_wp] <= i_pwdata;
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_pend   <= 1'b0;
            r_ovf    <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_tk     <= '0;
            r_half   <= '0;
            r_tone   <= '0;
            r_dur    <= '0;
            r_buzz   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_wr_ctrl) begin
                r_en     <= i_pwdata[0];
                r_irq_en <= i_pwdata[2];
            end
            // Hardware set beats a coincident write-1-to-clear
            r_pend <= w_set_pend | (r_pend & !(w_wr_stat & i_pwdata[3]));
            r_ovf  <= w_drop | (r_ovf & !(w_wr_stat & i_pwdata[4]));
            if (w_clr) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop) r_rp <= r_rp + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            r_pre <= (w_tick | (r_state != S_PLAY)) ? '0 : r_pre + PW'(1);
            if (r_state != S_PLAY) r_tk <= '0;
            else if (w_tick) r_tk <= w_ms ? '0 : r_tk + TW'(1);
            if (r_state == S_LOAD) begin
                r_half <= w_head[15:0];
                r_dur  <= (w_head[31:16] == 16'd0) ? 16'd1 : w_head[31:16];
                r_tone <= '0;
            end else begin
                if (w_tick & (r_half != 16'd0)) r_tone <= w_toggle ? '0 : r_tone + 16'd1;
                if (w_ms) r_dur <= r_dur - 16'd1;
            end
            r_buzz <= (w_state_n == S_PLAY) & (r_buzz ^ w_toggle);
        end
    end
endmodule

// File: tb/tb_apb_tone_seq.sv
// tb_apb_tone_seq: register vectors, note-sequencing scenarios and random note lists vs a timeline model
module tb_apb_tone_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0, penable = 1'b0, psel = 1'b0;
    logic [31:0] prdata;
    logic        pready, buzz, irq;

    apb_tone_seq #(.CLK_HZ(1_000_000), .TICK_HZ(100_000), .FIFO_DEPTH(4)) dut (
        .i_pclk(clk), .i_preset(rst), .i_paddr(paddr), .i_pwdata(pwdata),
        .i_pwrite(pwrite), .i_penable(penable), .i_psel(psel),
        .o_prdata(prdata), .o_pready(pready), .o_buzzer_tone(buzz), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {int dur; int half;} note_t;
    typedef struct {bit wr; logic [3:0] a; logic [31:0] d;} vec_t;

    note_t       q[$];
    vec_t        tbl[19];
    int          checks = 0, passed = 0;
    int          t, n, dur, half;
    logic [31:0] d;
    logic        r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        psel = 1'b1;
        pwrite = 1'b1;
        penable = 1'b0;
        paddr = a;
        pwdata = v;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] v, output logic rdy);
        @(negedge clk);
        psel = 1'b1;
        pwrite = 1'b0;
        penable = 1'b0;
        paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        v = prdata;
        rdy = pready;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic push(input logic [15:0] du, input logic [15:0] ha);
        apb_write(4'h4, {du, ha});
    endtask

    // Cycle j after the enabling CTRL write: first note's PLAY cycles are j=3..2+D*1000,
    // each later note starts one LOAD cycle after the previous one ends
    function automatic bit exp_buzz(int j);
        int s = 2;
        foreach (q[i]) begin
            int dd = q[i].dur * 1000;
            if (j > s && j <= s + dd) begin
                int k = j - s;
                return (k < dd) && (q[i].half != 0) && ((k / (10 * q[i].half)) % 2 == 1);
            end
            s += dd + 1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_end();
        int s = 2;
        int e = 0;
        foreach (q[i]) begin
            e = s + q[i].dur * 1000;
            s = e + 1;
        end
        return e;
    endfunction

    task automatic run_notes(input string name, input bit ovf, output int toggles);
        int jend, mism, first;
        logic prev;
        logic [31:0] v;
        logic rdy;
        jend = exp_end();
        mism = 0;
        first = -1;
        toggles = 0;
        apb_write(4'h0, 32'h5);
        prev = buzz;
        for (int j = 1; j <= jend + 20; j++) begin
            @(negedge clk);
            if (buzz !== prev) toggles++;
            prev = buzz;
            if (buzz !== exp_buzz(j) || irq !== (j >= jend)) begin
                mism++;
                if (first < 0) first = j;
            end
        end
        checks++;
        if (mism == 0) passed++;
        else $display("FAIL %s wave: %0d cycles wrong (first at cycle %0d), required 0", name, mism, first);
        apb_read(4'h8, v, rdy);
        chk({name, " status"}, {rdy, v}, {1'b1, 32'hC | (ovf ? 32'h10 : 32'h0)});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{0, 4'h0, 32'h0},        '{0, 4'h8, 32'h4},        '{0, 4'hC, 32'h0},
            '{1, 4'h0, 32'h6},        '{0, 4'h0, 32'h4},        '{1, 4'h0, 32'hFFFF_FFF9},
            '{0, 4'h0, 32'h1},        '{1, 4'h0, 32'h0},        '{1, 4'h4, 32'h0001_0005},
            '{0, 4'h4, 32'h0},        '{0, 4'h8, 32'h100},      '{1, 4'hC, 32'hFFFF_FFFF},
            '{0, 4'hC, 32'h0},        '{1, 4'h4, 32'h0002_0003}, '{0, 4'h8, 32'h200},
            '{1, 4'h8, 32'h18},       '{0, 4'h8, 32'h200},      '{1, 4'h0, 32'h2},
            '{0, 4'h8, 32'h4}
        };
        do_reset();
        chk("reset buzz", buzz, 0);
        chk("reset irq", irq, 0);
        chk("idle pready", pready, 0);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].a, tbl[i].d);
            else begin
                apb_read(tbl[i].a, d, r);
                chk($sformatf("vec%0d", i), {r, d}, {1'b1, tbl[i].d});
            end
        end
        @(negedge clk);
        paddr = 4'h8;
        #1;
        chk("unselected prdata", {pready, prdata}, 0);
        psel = 1'b1;
        pwrite = 1'b1;
        #1;
        chk("write setup prdata", {pready, prdata}, 0);
        @(negedge clk);
        psel = 1'b0;
        pwrite = 1'b0;

        do_reset();
        q = {};
        q.push_back('{2, 5});
        push(16'd2, 16'd5);
        run_notes("single note", 1'b0, t);
        chk("single note toggles", t, 40);

        do_reset();
        for (int i = 0; i < 5; i++) push(16'd1, 16'd1);
        apb_read(4'h8, d, r);
        chk("overflow status", {r, d}, {1'b1, 32'h412});
        apb_write(4'h8, 32'h10);
        apb_read(4'h8, d, r);
        chk("ovf w1c status", {r, d}, {1'b1, 32'h402});

        do_reset();
        q = {};
        q.push_back('{1, 3});
        q.push_back('{1, 0});
        q.push_back('{1, 4});
        push(16'd1, 16'd3);
        push(16'd1, 16'd0);
        push(16'd1, 16'd4);
        run_notes("three notes", 1'b0, t);
        chk("three notes toggles", t, 58);

        for (int it = 0; it < 3; it++) begin
            do_reset();
            q = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                dur = $urandom_range(0, 2);
                half = $urandom_range(0, 9);
                push(16'(dur), 16'(half));
                if (q.size() < 4) q.push_back('{(dur == 0) ? 1 : dur, half});
            end
            apb_read(4'h8, d, r);
            chk($sformatf("rand%0d fill", it), {r, d},
                {1'b1, 32'((n > 4 ? 4 : n) << 8) | (n > 4 ? 32'h10 : 32'h0) | (n >= 4 ? 32'h2 : 32'h0)});
            run_notes($sformatf("rand%0d", it), n > 4, t);
        end

        do_reset();
        push(16'd5, 16'd2);
        push(16'd1, 16'd3);
        apb_write(4'h0, 32'h1);
        repeat (310) @(negedge clk);
        chk("en-clear before", buzz, 1);
        apb_write(4'h0, 32'h0);
        chk("en-clear buzz", buzz, 0);
        apb_read(4'h8, d, r);
        chk("en-clear status", {r, d}, {1'b1, 32'h100});

        do_reset();
        for (int i = 0; i < 4; i++) push(16'd2, 16'd3);
        apb_write(4'h0, 32'h1);
        repeat (500) @(negedge clk);
        apb_read(4'h8, d, r);
        chk("clr pre status", {r, d}, {1'b1, 32'h301});
        apb_write(4'h0, 32'h3);
        chk("clr buzz", buzz, 0);
        apb_read(4'h8, d, r);
        chk("clr status", {r, d}, {1'b1, 32'h4});
        apb_write(4'h0, 32'h5);
        push(16'd1, 16'd0);
        repeat (1010) @(negedge clk);
        chk("pre-reset irq", irq, 1);
        push(16'd2, 16'd3);
        push(16'd2, 16'd3);
        repeat (300) @(negedge clk);
        do_reset();
        chk("mid-note reset buzz", buzz, 0);
        chk("mid-note reset irq", irq, 0);
        apb_read(4'h0, d, r);
        chk("mid-note reset ctrl", {r, d}, {1'b1, 32'h0});
        apb_read(4'h8, d, r);
        chk("mid-note reset status", {r, d}, {1'b1, 32'h4});

        do_reset();
        push(16'd1, 16'd0);
        apb_write(4'h0, 32'h1);
        repeat (999) @(negedge clk);
        apb_write(4'h8, 32'h8);
        apb_read(4'h8, d, r);
        chk("pend set wins", {r, d}, {1'b1, 32'hC});
        apb_write(4'h8, 32'h8);
        apb_read(4'h8, d, r);
        chk("pend w1c", {r, d}, {1'b1, 32'h4});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
